// File: rtl/mod12_count_monitor.sv
// mod12_count_monitor
// Passive checker for a mod-12 loadable up/down counter. It predicts each
// next count from the counter's control inputs and its observed count, flags
// every mismatch one cycle later, and keeps saturating error statistics.
//
// Optional build macro: MON_WRAP_CNT_EN
//   When defined, adds wrap_up_cnt / wrap_dn_cnt, which count wrap-around
//   transitions confirmed by a matched check.
//
// Handshake note: there is no valid/ready traffic here. Every rising edge
// with en=1 is an observation; en=0 parks the monitor in IDLE.
//
// dbg_state exposes the FSM encoding (0=IDLE, 1=TRACK, 2=LOCKED).

module mod12_count_monitor #(
  parameter int MAX_VAL  = 11,
  parameter int LOCK_LEN = 4,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic             ctr_reset,
  input  logic             ctr_load,
  input  logic             ctr_mode,
  input  logic [3:0]       ctr_data_in,
  input  logic [3:0]       ctr_count,
  output logic             mismatch,
  output logic             locked,
  output logic             err_sticky,
  output logic [ERR_W-1:0] err_cnt,
  output logic [3:0]       first_exp,
  output logic [3:0]       first_obs,
  output logic             out_of_range,
`ifdef MON_WRAP_CNT_EN
  output logic [7:0]       wrap_up_cnt,
  output logic [7:0]       wrap_dn_cnt,
`endif
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_TRACK  = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  localparam logic [3:0] MAX4  = 4'(MAX_VAL);
  localparam logic [4:0] LOCK5 = 5'(LOCK_LEN);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [3:0]         r_exp_q;
  logic [3:0]         r_run;
  logic               r_mismatch;
  logic               r_err_sticky;
  logic [ERR_W-1:0]   r_err_cnt;
  logic [3:0]         r_first_exp;
  logic [3:0]         r_first_obs;
  logic               r_oor;

  logic [3:0]         w_f;
  logic               w_check;
  logic               w_fail;
  logic               w_pass;
  logic [4:0]         w_run_inc;

  // Predicted next count; uses the observed count so each step stands alone.
  always_comb begin
    w_f = 4'd0;
    if (ctr_reset) begin
      w_f = 4'd0;
    end else if (ctr_load) begin
      w_f = ctr_data_in;
    end else if (!ctr_mode) begin
      w_f = (ctr_count == MAX4) ? 4'd0 : ctr_count + 4'd1;
    end else begin
      w_f = (ctr_count == 4'd0) ? MAX4 : ctr_count - 4'd1;
    end
  end

  // A compare happens only once a prediction exists (TRACK or LOCKED).
  assign w_check   = en && (r_state != S_IDLE);
  assign w_fail    = w_check && (ctr_count != r_exp_q);
  assign w_pass    = w_check && (ctr_count == r_exp_q);
  assign w_run_inc = {1'b0, r_run} + 5'd1;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    if (!en) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: w_state_nxt = S_TRACK;
        S_TRACK, S_LOCKED: begin
          if (w_fail) begin
            w_state_nxt = S_TRACK;
          end else if (w_run_inc >= LOCK5) begin
            w_state_nxt = S_LOCKED;
          end else begin
            w_state_nxt = S_TRACK;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // FSM outputs: locked is a pure decode of the registered state.
  always_comb begin
    locked    = (r_state == S_LOCKED);
    dbg_state = r_state;
  end

  // Prediction register and consecutive-pass run length.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_exp_q <= 4'd0;
      r_run   <= 4'd0;
    end else if (!en) begin
      r_run <= 4'd0;
    end else begin
      r_exp_q <= w_f;
      if (w_fail) begin
        r_run <= 4'd0;
      end else if (w_pass) begin
        r_run <= (w_run_inc >= LOCK5) ? LOCK5[3:0] : w_run_inc[3:0];
      end
    end
  end

  // One-cycle mismatch pulse and range flag; both drop whenever en=0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mismatch <= 1'b0;
      r_oor      <= 1'b0;
    end else begin
      r_mismatch <= w_fail;
      r_oor      <= en && (ctr_count > MAX4);
    end
  end

  // Error statistics; clr wins over a mismatch on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_cnt    <= '0;
      r_err_sticky <= 1'b0;
      r_first_exp  <= 4'd0;
      r_first_obs  <= 4'd0;
    end else if (clr) begin
      r_err_cnt    <= '0;
      r_err_sticky <= 1'b0;
      r_first_exp  <= 4'd0;
      r_first_obs  <= 4'd0;
    end else if (w_fail) begin
      if (!(&r_err_cnt)) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
      if (!r_err_sticky) begin
        r_err_sticky <= 1'b1;
        r_first_exp  <= r_exp_q;
        r_first_obs  <= ctr_count;
      end
    end
  end

  assign mismatch     = r_mismatch;
  assign err_sticky   = r_err_sticky;
  assign err_cnt      = r_err_cnt;
  assign first_exp    = r_first_exp;
  assign first_obs    = r_first_obs;
  assign out_of_range = r_oor;

`ifdef MON_WRAP_CNT_EN
  logic       r_up_pend;
  logic       r_dn_pend;
  logic [7:0] r_wrap_up;
  logic [7:0] r_wrap_dn;

  // Remember that the edge which produced exp_q was a free-running wrap step;
  // the wrap is credited only when the following check matches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_up_pend <= 1'b0;
      r_dn_pend <= 1'b0;
    end else if (!en) begin
      r_up_pend <= 1'b0;
      r_dn_pend <= 1'b0;
    end else begin
      r_up_pend <= !ctr_reset && !ctr_load && !ctr_mode && (ctr_count == MAX4);
      r_dn_pend <= !ctr_reset && !ctr_load &&  ctr_mode && (ctr_count == 4'd0);
    end
  end

  // Wrap counters, modulo 256, cleared by clr.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrap_up <= 8'd0;
      r_wrap_dn <= 8'd0;
    end else if (clr) begin
      r_wrap_up <= 8'd0;
      r_wrap_dn <= 8'd0;
    end else begin
      if (w_pass && r_up_pend) begin
        r_wrap_up <= r_wrap_up + 8'd1;
      end
      if (w_pass && r_dn_pend) begin
        r_wrap_dn <= r_wrap_dn + 8'd1;
      end
    end
  end

  assign wrap_up_cnt = r_wrap_up;
  assign wrap_dn_cnt = r_wrap_dn;
`endif

endmodule

// File: tb/tb_mod12_count_monitor.sv
// Directed bench for mod12_count_monitor. The counter is not instantiated:
// its count and control inputs are driven as hand-written vectors, and every
// expected monitor output below is worked out by hand from those vectors.

module tb_mod12_count_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       clr;
  logic       ctr_reset;
  logic       ctr_load;
  logic       ctr_mode;
  logic [3:0] ctr_data_in;
  logic [3:0] ctr_count;
  logic       mismatch;
  logic       locked;
  logic       err_sticky;
  logic [7:0] err_cnt;
  logic [3:0] first_exp;
  logic [3:0] first_obs;
  logic       out_of_range;
  logic [1:0] dbg_state;
`ifdef MON_WRAP_CNT_EN
  logic [7:0] wrap_up_cnt;
  logic [7:0] wrap_dn_cnt;
`endif

  int checks = 0;
  int errors = 0;

  mod12_count_monitor #(.MAX_VAL(11), .LOCK_LEN(4), .ERR_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .clr          (clr),
    .ctr_reset    (ctr_reset),
    .ctr_load     (ctr_load),
    .ctr_mode     (ctr_mode),
    .ctr_data_in  (ctr_data_in),
    .ctr_count    (ctr_count),
    .mismatch     (mismatch),
    .locked       (locked),
    .err_sticky   (err_sticky),
    .err_cnt      (err_cnt),
    .first_exp    (first_exp),
    .first_obs    (first_obs),
    .out_of_range (out_of_range),
`ifdef MON_WRAP_CNT_EN
    .wrap_up_cnt  (wrap_up_cnt),
    .wrap_dn_cnt  (wrap_dn_cnt),
`endif
    .dbg_state    (dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one edge: set inputs, wait for the rising edge, settle 1 time unit.
  task automatic step(input logic e, input logic c, input logic rs, input logic ld,
                      input logic md, input logic [3:0] d, input logic [3:0] cnt);
    en = e; clr = c; ctr_reset = rs; ctr_load = ld; ctr_mode = md;
    ctr_data_in = d; ctr_count = cnt;
    @(posedge clk);
    #1;
  endtask

  task automatic up(input logic [3:0] cnt);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, cnt);
  endtask

  task automatic dn(input logic [3:0] cnt);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, cnt);
  endtask

  task automatic ld(input logic [3:0] cnt, input logic [3:0] d);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, d, cnt);
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; clr = 1'b0; ctr_reset = 1'b0; ctr_load = 1'b0;
    ctr_mode = 1'b0; ctr_data_in = 4'd0; ctr_count = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mismatch", 32'(mismatch), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_sticky", 32'(err_sticky), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    chk("rst_first_exp", 32'(first_exp), 0);
    chk("rst_first_obs", 32'(first_obs), 0);
    chk("rst_oor", 32'(out_of_range), 0);
    chk("rst_state", 32'(dbg_state), 0);
    reset = 1'b0;

    // Up count from load 9: observed 9,10,11,0,1,2.
    ld(4'd0, 4'd9);                      // IDLE -> TRACK, exp=9, no compare
    chk("up_first_state", 32'(dbg_state), 1);
    up(4'd9);  chk("up9_mm", 32'(mismatch), 0);
    up(4'd10); chk("up10_mm", 32'(mismatch), 0);
    up(4'd11); chk("up11_locked", 32'(locked), 0);
    up(4'd0);  chk("up0_locked", 32'(locked), 1);
               chk("up0_mm", 32'(mismatch), 0);
    up(4'd1);  chk("up1_mm", 32'(mismatch), 0);
    up(4'd2);  chk("up2_mm", 32'(mismatch), 0);
               chk("up_err_cnt", 32'(err_cnt), 0);
               chk("up_locked_hold", 32'(locked), 1);
`ifdef MON_WRAP_CNT_EN
    chk("wrap_up_1", 32'(wrap_up_cnt), 1);
`endif

    // Down count from 1: observed 1,0,11,10 (exp=3 at this point).
    ld(4'd3, 4'd1);
    dn(4'd1);  chk("dn1_mm", 32'(mismatch), 0);
    dn(4'd0);  chk("dn0_mm", 32'(mismatch), 0);
    dn(4'd11); chk("dn11_mm", 32'(mismatch), 0);
    dn(4'd10); chk("dn10_mm", 32'(mismatch), 0);
               chk("dn_err_cnt", 32'(err_cnt), 0);
`ifdef MON_WRAP_CNT_EN
    chk("wrap_dn_1", 32'(wrap_dn_cnt), 1);
`endif

    // Forced fault: counter at 5, up, observed 7 instead of 6 (exp=9 now).
    ld(4'd9, 4'd5);
    up(4'd5);
    up(4'd7);  chk("flt_mm", 32'(mismatch), 1);
               chk("flt_err_cnt", 32'(err_cnt), 1);
               chk("flt_first_exp", 32'(first_exp), 6);
               chk("flt_first_obs", 32'(first_obs), 7);
               chk("flt_locked", 32'(locked), 0);
               chk("flt_sticky", 32'(err_sticky), 1);
    up(4'd8);  chk("flt_pulse_end", 32'(mismatch), 0);
    up(4'd9);
    up(4'd10); chk("relock_3", 32'(locked), 0);
    up(4'd11); chk("relock_4", 32'(locked), 1);

    // Load 14 then up count: 14,15,0 accepted, out_of_range on 14 and 15.
    ld(4'd0, 4'd14); chk("l14_oor", 32'(out_of_range), 0);
`ifdef MON_WRAP_CNT_EN
    chk("wrap_up_2", 32'(wrap_up_cnt), 2);
`endif
    up(4'd14); chk("c14_oor", 32'(out_of_range), 1);
               chk("c14_mm", 32'(mismatch), 0);
    up(4'd15); chk("c15_oor", 32'(out_of_range), 1);
               chk("c15_mm", 32'(mismatch), 0);
    up(4'd0);  chk("c0_oor", 32'(out_of_range), 0);
               chk("c0_mm", 32'(mismatch), 0);
               chk("c0_err_cnt", 32'(err_cnt), 1);
`ifdef MON_WRAP_CNT_EN
    chk("wrap_up_still_2", 32'(wrap_up_cnt), 2);
`endif

    // 300 faults: ctr_reset=1 predicts 0 but count 5 is observed each edge.
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd5);
    end
    chk("sat_err_cnt", 32'(err_cnt), 255);
    chk("sat_mm", 32'(mismatch), 1);
    chk("sat_first_exp", 32'(first_exp), 6);
    chk("sat_first_obs", 32'(first_obs), 7);
    // clr and a fault on the same edge.
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd5);
    chk("clr_err_cnt", 32'(err_cnt), 0);
    chk("clr_sticky", 32'(err_sticky), 0);
    chk("clr_first_exp", 32'(first_exp), 0);
    chk("clr_mm", 32'(mismatch), 1);
    // First fault after clr is captured afresh.
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd5);
    chk("recap_err_cnt", 32'(err_cnt), 1);
    chk("recap_first_exp", 32'(first_exp), 0);
    chk("recap_first_obs", 32'(first_obs), 5);

    // Four good checks, then async reset between edges.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    end
    chk("pre_rst_locked", 32'(locked), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_locked", 32'(locked), 0);
    chk("arst_err_cnt", 32'(err_cnt), 0);
    chk("arst_sticky", 32'(err_sticky), 0);
    chk("arst_first_obs", 32'(first_obs), 0);
    chk("arst_state", 32'(dbg_state), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // en=0 mid-run: stats retained, no compare on the first edge back.
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);   // IDLE -> TRACK, exp=0
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd3);   // fault
    chk("en_fault_cnt", 32'(err_cnt), 1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd13);  // en=0
    chk("en0_state", 32'(dbg_state), 0);
    chk("en0_mm", 32'(mismatch), 0);
    chk("en0_oor", 32'(out_of_range), 0);
    chk("en0_err_cnt", 32'(err_cnt), 1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd9);   // would mismatch if compared
    chk("en1_no_cmp_mm", 32'(mismatch), 0);
    chk("en1_no_cmp_cnt", 32'(err_cnt), 1);
    chk("en1_state", 32'(dbg_state), 1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    chk("en1_match_mm", 32'(mismatch), 0);
    chk("en1_sticky", 32'(err_sticky), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
